// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-bus handshakes around mem_port_arbiter.
// The master modport is the arbiter's view; slave is the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_flush;
  logic                  i_resp_valid;
  logic [31:0]           i_resp_data;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [ADDR_W-1:0]     d_addr;
  logic                  d_wen;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_resp_valid;
  logic [DATA_W-1:0]     d_resp_data;

  logic                  m_req_valid;
  logic                  m_req_ready;
  logic [ADDR_W-1:0]     m_addr;
  logic                  m_wen;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_resp_valid;
  logic [DATA_W-1:0]     m_resp_data;

  modport master (
    input  i_req_valid, i_addr, i_flush,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_addr, d_wen, d_wstrb, d_wdata,
    output d_req_ready, d_resp_valid, d_resp_data,
    output m_req_valid, m_addr, m_wen, m_wstrb, m_wdata,
    input  m_req_ready, m_resp_valid, m_resp_data
  );

  modport slave (
    output i_req_valid, i_addr, i_flush,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_addr, d_wen, d_wstrb, d_wdata,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  m_req_valid, m_addr, m_wen, m_wstrb, m_wdata,
    output m_req_ready, m_resp_valid, m_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-style memory port between instruction fetch (read-only) and load/store.
// D has fixed priority, I is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  state_e                state_q;
  logic                  owner_d_q;
  logic                  kill_q;
  logic [3:0]            starve_q;
  logic                  m_req_valid_q;
  logic [ADDR_W-1:0]     m_addr_q;
  logic                  m_wen_q;
  logic [DATA_W/8-1:0]   m_wstrb_q;
  logic [DATA_W-1:0]     m_wdata_q;

  logic i_ok, d_win, grant_i, grant_d, resp_fire, i_kill_now;

  always_comb begin
    // A fetch being redirected this cycle is treated as not requesting.
    i_ok       = bus.i_req_valid & ~bus.i_flush;
    d_win      = bus.d_req_valid & ((starve_q < StarveLim) | ~i_ok);
    grant_d    = ~reset & (state_q == StIdle) & d_win;
    grant_i    = ~reset & (state_q == StIdle) & ~d_win & i_ok;
    resp_fire  = ~reset & (state_q == StResp) & bus.m_resp_valid;
    i_kill_now = bus.i_flush & ~owner_d_q;
  end

  assign bus.i_req_ready  = grant_i;
  assign bus.d_req_ready  = grant_d;
  assign bus.d_resp_valid = resp_fire & owner_d_q;
  assign bus.d_resp_data  = (resp_fire & owner_d_q) ? bus.m_resp_data : '0;
  assign bus.i_resp_valid = resp_fire & ~owner_d_q & ~kill_q & ~bus.i_flush;
  assign bus.i_resp_data  = (resp_fire & ~owner_d_q & ~kill_q & ~bus.i_flush) ?
                            bus.m_resp_data[31:0] : '0;

  assign bus.m_req_valid = m_req_valid_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_wen       = m_wen_q;
  assign bus.m_wstrb     = m_wstrb_q;
  assign bus.m_wdata     = m_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      owner_d_q     <= 1'b0;
      kill_q        <= 1'b0;
      starve_q      <= '0;
      m_req_valid_q <= 1'b0;
      m_addr_q      <= '0;
      m_wen_q       <= 1'b0;
      m_wstrb_q     <= '0;
      m_wdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            m_addr_q      <= bus.d_addr;
            m_wen_q       <= bus.d_wen;
            m_wstrb_q     <= bus.d_wstrb;
            m_wdata_q     <= bus.d_wdata;
            owner_d_q     <= 1'b1;
            kill_q        <= 1'b0;
            m_req_valid_q <= 1'b1;
            state_q       <= StReq;
            if (i_ok && starve_q != 4'hF) starve_q <= starve_q + 4'd1;
          end else if (grant_i) begin
            m_addr_q      <= bus.i_addr;
            m_wen_q       <= 1'b0;
            m_wstrb_q     <= '0;
            m_wdata_q     <= '0;
            owner_d_q     <= 1'b0;
            kill_q        <= 1'b0;
            m_req_valid_q <= 1'b1;
            state_q       <= StReq;
            starve_q      <= '0;
          end
        end
        StReq: begin
          if (i_kill_now) kill_q <= 1'b1;
          if (bus.m_req_ready) begin
            m_req_valid_q <= 1'b0;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (i_kill_now) kill_q <= 1'b1;
          if (bus.m_resp_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, starvation override, flush, stall, reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_req_valid  = 1'b0;
    bus.i_addr       = '0;
    bus.i_flush      = 1'b0;
    bus.d_req_valid  = 1'b0;
    bus.d_addr       = '0;
    bus.d_wen        = 1'b0;
    bus.d_wstrb      = '0;
    bus.d_wdata      = '0;
    bus.m_req_ready  = 1'b0;
    bus.m_resp_valid = 1'b0;
    bus.m_resp_data  = '0;
  endtask

  // Inputs are driven just after a rising edge; checks happen at the falling edge.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".m_req_valid"}, 64'(bus.m_req_valid), 64'd0);
    check({tag, ".m_addr"},      64'(bus.m_addr),      64'd0);
    check({tag, ".m_wen"},       64'(bus.m_wen),       64'd0);
    check({tag, ".m_wstrb"},     64'(bus.m_wstrb),     64'd0);
    check({tag, ".m_wdata"},     bus.m_wdata,          64'd0);
    check({tag, ".i_resp_v"},    64'(bus.i_resp_valid), 64'd0);
    check({tag, ".d_resp_v"},    64'(bus.d_resp_valid), 64'd0);
    check({tag, ".i_resp_d"},    64'(bus.i_resp_data),  64'd0);
    check({tag, ".d_resp_d"},    bus.d_resp_data,       64'd0);
  endtask

  string exp_seq;
  string got_seq;

  initial begin
    clear_inputs();
    reset = 1'b1;
    nxt();
    // Requests during reset must not be granted.
    bus.i_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    mid();
    check("rst.i_ready", 64'(bus.i_req_ready), 64'd0);
    check("rst.d_ready", 64'(bus.d_req_ready), 64'd0);
    check_all_zero("rst");
    nxt();
    reset = 1'b0;
    clear_inputs();

    // Lone I request
    bus.i_req_valid = 1'b1;
    bus.i_addr      = 32'h8000_0000;
    bus.m_req_ready = 1'b1;
    mid();
    check("i1.i_ready", 64'(bus.i_req_ready), 64'd1);
    check("i1.d_ready", 64'(bus.d_req_ready), 64'd0);
    check("i1.m_valid_early", 64'(bus.m_req_valid), 64'd0);
    nxt();
    bus.i_req_valid = 1'b0;
    mid();
    check("i1.m_valid", 64'(bus.m_req_valid), 64'd1);
    check("i1.m_addr",  64'(bus.m_addr), 64'h8000_0000);
    check("i1.m_wen",   64'(bus.m_wen), 64'd0);
    check("i1.i_ready_off", 64'(bus.i_req_ready), 64'd0);
    nxt();
    mid();
    check("i1.m_valid_drop", 64'(bus.m_req_valid), 64'd0);
    check("i1.no_resp_yet", 64'(bus.i_resp_valid), 64'd0);
    nxt();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'hFFFF_FFFF_0000_0013;
    mid();
    check("i1.i_resp_v", 64'(bus.i_resp_valid), 64'd1);
    check("i1.i_resp_d", 64'(bus.i_resp_data), 64'h13);
    check("i1.d_resp_v", 64'(bus.d_resp_valid), 64'd0);
    nxt();
    bus.m_resp_valid = 1'b0;
    mid();
    check("i1.i_resp_pulse", 64'(bus.i_resp_valid), 64'd0);
    nxt();

    // I and D together: D store goes first, I right after the D response
    bus.i_req_valid = 1'b1;
    bus.i_addr      = 32'h0000_0400;
    bus.d_req_valid = 1'b1;
    bus.d_addr      = 32'h0000_0100;
    bus.d_wen       = 1'b1;
    bus.d_wstrb     = 8'hFF;
    bus.d_wdata     = 64'h1122_3344_5566_7788;
    mid();
    check("id.d_ready", 64'(bus.d_req_ready), 64'd1);
    check("id.i_ready", 64'(bus.i_req_ready), 64'd0);
    nxt();
    bus.d_req_valid = 1'b0;
    bus.d_wen       = 1'b0;
    bus.d_wstrb     = '0;
    bus.d_wdata     = '0;
    mid();
    check("id.m_addr",  64'(bus.m_addr), 64'h100);
    check("id.m_wen",   64'(bus.m_wen), 64'd1);
    check("id.m_wstrb", 64'(bus.m_wstrb), 64'hFF);
    check("id.m_wdata", bus.m_wdata, 64'h1122_3344_5566_7788);
    check("id.i_ready_req", 64'(bus.i_req_ready), 64'd0);
    nxt();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'h0000_0000_0000_00AA;
    mid();
    check("id.d_resp_v", 64'(bus.d_resp_valid), 64'd1);
    check("id.d_resp_d", bus.d_resp_data, 64'hAA);
    check("id.i_resp_v", 64'(bus.i_resp_valid), 64'd0);
    nxt();
    bus.m_resp_valid = 1'b0;
    mid();
    check("id.i_ready_after", 64'(bus.i_req_ready), 64'd1);
    nxt();
    bus.i_req_valid = 1'b0;
    nxt();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'h0000_0000_0000_0033;
    mid();
    check("id.i_resp_d", 64'(bus.i_resp_data), 64'h33);
    nxt();
    bus.m_resp_valid = 1'b0;

    // Starvation: both held valid, memory always ready and responding
    bus.i_req_valid  = 1'b1;
    bus.i_addr       = 32'h0000_0500;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h0000_0600;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'h55;
    exp_seq = "DDDDID";
    got_seq = "";
    for (int c = 0; c < 18; c++) begin
      mid();
      if (bus.d_req_ready) got_seq = {got_seq, "D"};
      if (bus.i_req_ready) got_seq = {got_seq, "I"};
      nxt();
    end
    n_total++;
    if (got_seq != exp_seq) begin
      n_bad++;
      $display("FAIL starve.seq: got %s expected %s", got_seq, exp_seq);
    end
    clear_inputs();

    // Flush while I is in RESP: response is dropped, next fetch served normally
    bus.i_req_valid = 1'b1;
    bus.i_addr      = 32'h0000_0300;
    bus.m_req_ready = 1'b1;
    mid();
    check("fl.i_ready", 64'(bus.i_req_ready), 64'd1);
    nxt();
    bus.i_req_valid = 1'b0;
    nxt();
    bus.i_flush = 1'b1;
    nxt();
    bus.i_flush      = 1'b0;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'h0000_0000_DEAD_BEEF;
    mid();
    check("fl.i_resp_killed", 64'(bus.i_resp_valid), 64'd0);
    check("fl.d_resp_v", 64'(bus.d_resp_valid), 64'd0);
    nxt();
    bus.m_resp_valid = 1'b0;
    bus.i_req_valid  = 1'b1;
    bus.i_addr       = 32'h0000_0200;
    mid();
    check("fl.regrant", 64'(bus.i_req_ready), 64'd1);
    nxt();
    bus.i_req_valid = 1'b0;
    mid();
    check("fl.m_addr", 64'(bus.m_addr), 64'h200);
    nxt();
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'h0000_0000_1234_5678;
    mid();
    check("fl.i_resp_v", 64'(bus.i_resp_valid), 64'd1);
    check("fl.i_resp_d", 64'(bus.i_resp_data), 64'h1234_5678);
    nxt();
    clear_inputs();

    // Memory stall: request fields hold, nobody else is granted
    bus.d_req_valid = 1'b1;
    bus.d_addr      = 32'h0000_0040;
    bus.d_wen       = 1'b1;
    bus.d_wstrb     = 8'h0F;
    bus.d_wdata     = 64'hCAFE_F00D_0BAD_BEEF;
    mid();
    check("st.d_ready", 64'(bus.d_req_ready), 64'd1);
    nxt();
    bus.i_req_valid = 1'b1;
    bus.d_addr      = 32'h0000_0999;
    bus.d_wdata     = '0;
    for (int c = 0; c < 5; c++) begin
      mid();
      check("st.m_valid", 64'(bus.m_req_valid), 64'd1);
      check("st.m_addr",  64'(bus.m_addr), 64'h40);
      check("st.m_wen",   64'(bus.m_wen), 64'd1);
      check("st.m_wstrb", 64'(bus.m_wstrb), 64'h0F);
      check("st.m_wdata", bus.m_wdata, 64'hCAFE_F00D_0BAD_BEEF);
      check("st.i_ready", 64'(bus.i_req_ready), 64'd0);
      check("st.d_ready", 64'(bus.d_req_ready), 64'd0);
      nxt();
    end
    clear_inputs();
    bus.m_req_ready = 1'b1;
    nxt();
    bus.m_req_ready  = 1'b0;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'h77;
    mid();
    check("st.d_resp_v", 64'(bus.d_resp_valid), 64'd1);
    nxt();
    clear_inputs();

    // Reset during REQ
    bus.i_req_valid = 1'b1;
    bus.i_addr      = 32'h0000_0700;
    nxt();
    bus.i_req_valid = 1'b0;
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'h99;
    bus.d_req_valid  = 1'b1;
    bus.d_addr       = 32'h0000_0080;
    mid();
    check_all_zero("rreq");
    check("rreq.idle_grant", 64'(bus.d_req_ready), 64'd1);
    nxt();
    clear_inputs();
    bus.m_req_ready = 1'b1;
    nxt();
    bus.m_req_ready = 1'b0;
    // Reset during RESP
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    bus.m_resp_valid = 1'b1;
    bus.m_resp_data  = 64'hAB;
    mid();
    check_all_zero("rresp");
    nxt();
    clear_inputs();
    nxt();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (I side, read-only) and load/store (D side, read/write).
- Sits between the fetch stage / memory-access stage and the SRAM-style memory bus.
- Arbitrates requests with fixed priority for D plus an anti-starvation override for I.
- Keeps one outstanding transaction and routes each response back to the requester that issued it.
- Supports a fetch flush: an in-flight I response is discarded after a PC redirect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width on the D side and the memory side. I data is the low 32 bits.
- STARVE_LIMIT, 4, consecutive I losses before I is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_addr  in  ADDR_W  fetch address
- i_flush  in  1  fetch redirect; kills any pending I transaction
- i_resp_valid  out  1  instruction data valid, one-cycle pulse
- i_resp_data  out  32  instruction word
- d_req_valid  in  1  load/store request valid
- d_req_ready  out  1  load/store request accepted this cycle
- d_addr  in  ADDR_W  data address
- d_wen  in  1  1 = store, 0 = load
- d_wstrb  in  DATA_W/8  byte write strobes
- d_wdata  in  DATA_W  store data
- d_resp_valid  out  1  load data / store acknowledge, one-cycle pulse
- d_resp_data  out  DATA_W  load data
- m_req_valid  out  1  memory request valid (registered)
- m_req_ready  in  1  memory accepts request
- m_addr  out  ADDR_W  registered address
- m_wen  out  1  registered write enable; always 0 for I requests
- m_wstrb  out  DATA_W/8  registered strobes; all 0 for I requests
- m_wdata  out  DATA_W  registered write data
- m_resp_valid  in  1  memory response valid; always accepted
- m_resp_data  in  DATA_W  memory response data

Behaviour:
- Reset: state=IDLE, owner=I, kill=0, starve_cnt=0. All outputs are 0: m_req_valid, m_addr, m_wen, m_wstrb, m_wdata, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, and both resp_data buses.
- Reset wins over every other input. A reset in REQ or RESP drops the transaction silently and produces no response pulse.
- FSM has three states: IDLE, REQ, RESP.
- IDLE:
  - Grant is combinational. If d_req_valid is high and starve_cnt < STARVE_LIMIT (or i_req_valid is low), D wins. Otherwise, if i_req_valid is high, I wins.
  - An I request with i_flush high in the same cycle is not granted.
  - Only the winner's *_req_ready is 1. Both are 0 outside IDLE.
  - On a grant, the winner's request fields are latched into the m_* registers, owner is recorded, kill is cleared, and the FSM moves to REQ. m_req_valid is 1 from the next cycle, so grant-to-bus latency is 1 cycle.
- starve_cnt:
  - Increments (saturating) in a cycle where both requesters are valid and D wins.
  - Clears whenever I is granted.
  - Holds otherwise.
- REQ:
  - m_req_valid=1 and the m_* fields hold stable until m_req_ready is seen.
  - On m_req_valid & m_req_ready: m_req_valid drops in the next cycle and the FSM moves to RESP.
- RESP:
  - Waits for m_resp_valid; there is no timeout.
  - In the cycle m_resp_valid is high, the response is forwarded combinationally: owner=D gives d_resp_valid=1 and d_resp_data=m_resp_data; owner=I and kill=0 gives i_resp_valid=1 and i_resp_data=m_resp_data[31:0].
  - The FSM returns to IDLE in the next cycle, so a new grant can occur 1 cycle after the response.
  - A response that arrives in REQ, or in IDLE, is ignored.
- Flush:
  - i_flush high while owner=I and state is REQ or RESP sets kill=1.
  - The memory transaction still completes, but i_resp_valid is suppressed.
  - i_flush in the same cycle as m_resp_valid also suppresses that pulse.
  - i_flush has no effect on a D transaction.
- Only one transaction is ever outstanding. Back-to-back throughput is at most one access per 3 cycles with zero memory latency.

Test Plan:
- Lone I request, addr=0x80000000, memory ready immediately, response 0x00000013 two cycles later -> i_req_ready pulses 1 cycle, m_req_valid the next cycle, i_resp_valid=1 with i_resp_data=0x00000013, d_resp_valid stays 0.
- I and D valid together, D is a store at 0x100 with wstrb=0xFF and wdata=0x1122334455667788 -> D granted first and m_wen=1 with the exact fields; I granted in the IDLE cycle after the D response.
- I and D held valid continuously, STARVE_LIMIT=4 -> sequence D,D,D,D,I,D..., with starve_cnt 0→4 and then cleared on the I grant.
- I granted, then i_flush pulsed while in RESP, response 0xDEADBEEF arrives -> i_resp_valid stays 0; a new I request at 0x200 is then granted and served normally.
- m_req_ready held low for 5 cycles -> m_addr/m_wen/m_wstrb/m_wdata stable, m_req_valid=1 throughout, and neither *_req_ready asserts.
- Reset asserted in REQ and in RESP -> next cycle all outputs are 0 and state is IDLE; a late m_resp_valid produces no response pulse.
